host_mem_responder: RTL and testbench
=====================================

Name: host_mem_responder

Overview:
- Host-side memory model and bus responder for the kernel wrappers' word-serial read/write handshake.
- Serves read requests from an internal word array and commits write-back data to it.
- Counts transfers and busy cycles for performance reporting.
- Sits directly upstream/downstream of the kernel wrapper: it drives read_ready/read_data/write_ready and consumes read_enable/read_addr/finish_read/write_enable/write_addr/write_data/finish_write/done.

Parameters:
- ADDR_WID, 16, word-index width; the array holds 2^ADDR_WID 32-bit words.
- BASE, 64'h0, byte address of word 0.
- RD_LAT, 3, cycles from read request acceptance to read_ready (>=1).
- WR_LAT, 2, cycles from write request acceptance to write_ready (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- read_enable  in  1  wrapper read phase active.
- read_addr  in  64  byte address of requested word.
- finish_read  in  1  wrapper's one-cycle acknowledge of consumed word.
- read_ready  out  64  1 for exactly one cycle when read_data is valid, else 0.
- read_data  out  32  word returned.
- write_enable  in  1  wrapper write phase active.
- write_addr  in  64  byte address of word to write.
- write_data  in  32  word to write.
- finish_write  in  1  wrapper's one-cycle acknowledge of write.
- write_ready  out  64  1 for exactly one cycle when the write is committed, else 0.
- done  in  1  wrapper completion pulse.
- pre_we  in  1  testbench preload strobe.
- pre_addr  in  ADDR_WID  preload/inspect word index.
- pre_data  in  32  preload word.
- dbg_data  out  32  mem[pre_addr], registered, one-cycle latency.
- rd_count  out  32  words returned since reset.
- wr_count  out  32  words committed since reset.
- busy_cycles  out  64  cycles from first accepted request to done.
- err  out  1  sticky out-of-range flag.
- finished  out  1  sticky, set on done.

Behaviour:
- Reset is synchronous and active-high. All outputs go to 0, the FSM goes to IDLE, and counters clear. Memory contents are not cleared.
- Word index = (addr - BASE) >> 2. In range iff addr >= BASE, (addr - BASE)[1:0] == 0, and index < 2^ADDR_WID.
- FSM states: IDLE, RD_WAIT, RD_VALID, RD_ACK, WR_WAIT, WR_VALID, WR_ACK.
- IDLE:
  - read_enable=1: latch read_addr, load lat_cnt = RD_LAT-1, go to RD_WAIT.
  - Otherwise write_enable=1: latch write_addr and write_data, load lat_cnt = WR_LAT-1, go to WR_WAIT.
  - Read wins if both are asserted.
- RD_WAIT: decrement lat_cnt. At 0, register read_data = mem[index] (32'hDEADBEEF and err<=1 if out of range), go to RD_VALID.
- RD_VALID: read_ready=1 for this cycle only; rd_count+1; go to RD_ACK.
- RD_ACK: wait for finish_read=1 or read_enable=0, then go to IDLE. The wrapper updates read_addr in the same cycle it raises finish_read, so the next request is sampled in IDLE.
- Last word: the wrapper drops read_enable instead of pulsing finish_read; RD_ACK exits on read_enable=0.
- Read latency from IDLE acceptance cycle T: read_ready high at T+RD_LAT+1.
- WR_WAIT: decrement lat_cnt; at 0 go to WR_VALID.
- WR_VALID: mem[index] <= latched data (dropped and err<=1 if out of range); write_ready=1 for one cycle; wr_count+1; go to WR_ACK.
- WR_ACK: exit to IDLE on finish_write=1 or write_enable=0.
- Write-data timing: the wrapper presents the next write_data in the cycle after write_ready, so data is always latched in IDLE.
- read_data holds its last value outside RD_VALID.
- busy_cycles:
  - Starts counting on the first IDLE acceptance after reset.
  - Stops when done=1; finished<=1.
  - Further requests after finished are still served, but busy_cycles stays frozen.
- Enable dropped mid-transaction (RD_WAIT/WR_WAIT): the transaction completes and the ready pulse is still issued; the ack state exits immediately.
- pre_we writes mem[pre_addr] in any state. If it hits the same word in the same cycle as a WR_VALID commit, the handshake write wins.
- Reset mid-transaction: abort, no ready pulse, no memory update.
- Counters wrap modulo 2^width.

Test Plan:
- Preload mem[0..3] = 10,20,30,40. Wrapper reads 4 words (BASE=0, step 4), RD_LAT=3 -> read_data 10,20,30,40; each read_ready exactly 1 cycle, 4 cycles after acceptance; rd_count=4.
- Write 4 words 100..103 to BASE, WR_LAT=2 -> dbg_data at pre_addr 0..3 reads 100..103; wr_count=4; write_ready single-cycle pulses.
- read_addr=BASE+2 (misaligned) -> read_data 32'hDEADBEEF, err=1 and stays 1 through later valid traffic.
- read_enable and write_enable both high in IDLE -> read served first, then write; write data unchanged.
- Full wrapper run (read 64, kernel, write 64, done) -> finished=1, busy_cycles frozen, counts 64/64.
- Reset asserted during RD_WAIT -> no read_ready, all outputs 0, next request served normally.

Source files
------------

// File: rtl/host_mem_responder.sv
// Host-side word memory and responder for the kernel wrapper's word-serial
// read/write handshake, with transfer counters and a busy-cycle meter.
module host_mem_responder #(
    parameter int          ADDR_WID = 16,
    parameter logic [63:0] BASE     = 64'h0,
    parameter int          RD_LAT   = 3,
    parameter int          WR_LAT   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read_enable,
    input  logic [63:0]         read_addr,
    input  logic                finish_read,
    output logic [63:0]         read_ready,
    output logic [31:0]         read_data,
    input  logic                write_enable,
    input  logic [63:0]         write_addr,
    input  logic [31:0]         write_data,
    input  logic                finish_write,
    output logic [63:0]         write_ready,
    input  logic                done,
    input  logic                pre_we,
    input  logic [ADDR_WID-1:0] pre_addr,
    input  logic [31:0]         pre_data,
    output logic [31:0]         dbg_data,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count,
    output logic [63:0]         busy_cycles,
    output logic                err,
    output logic                finished
);

    localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [31:0] BAD_WORD = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_VALID,
        S_RD_ACK,
        S_WR_WAIT,
        S_WR_VALID,
        S_WR_ACK
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0]         r_mem [0:(2**ADDR_WID)-1];
    logic [CNT_W-1:0]    r_lat_cnt;
    logic [63:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_read_data;
    logic [31:0]         r_dbg_data;
    logic [31:0]         r_rd_count;
    logic [31:0]         r_wr_count;
    logic [63:0]         r_busy_cycles;
    logic                r_started;
    logic                r_finished;
    logic                r_err;

    logic                w_accept_rd;
    logic                w_accept_wr;
    logic                w_rd_fetch;
    logic                w_wr_commit;
    logic                w_counting;
    logic [63:0]         w_offset;
    logic                w_in_range;
    logic [ADDR_WID-1:0] w_index;

    // Address decode works on the latched request address only.
    assign w_offset   = r_addr - BASE;
    assign w_in_range = (r_addr >= BASE) && (w_offset[1:0] == 2'b00) &&
                        (w_offset[63:ADDR_WID+2] == '0);
    assign w_index    = w_offset[ADDR_WID+1:2];

    always_comb begin
        w_state_next = r_state;
        w_accept_rd  = 1'b0;
        w_accept_wr  = 1'b0;
        w_rd_fetch   = 1'b0;
        w_wr_commit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (read_enable) begin
                    w_accept_rd  = 1'b1;
                    w_state_next = S_RD_WAIT;
                end else if (write_enable) begin
                    w_accept_wr  = 1'b1;
                    w_state_next = S_WR_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_rd_fetch   = 1'b1;
                    w_state_next = S_RD_VALID;
                end
            end
            S_RD_VALID: w_state_next = S_RD_ACK;
            S_RD_ACK: begin
                if (finish_read || !read_enable) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WR_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_next = S_WR_VALID;
                end
            end
            S_WR_VALID: begin
                w_wr_commit  = 1'b1;
                w_state_next = S_WR_ACK;
            end
            S_WR_ACK: begin
                if (finish_write || !write_enable) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The meter runs from the first accepted request up to (not including) done.
    assign w_counting = (r_started || w_accept_rd || w_accept_wr) &&
                        !r_finished && !done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_lat_cnt     <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_read_data   <= '0;
            r_rd_count    <= '0;
            r_wr_count    <= '0;
            r_busy_cycles <= '0;
            r_started     <= 1'b0;
            r_finished    <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_accept_rd) begin
                r_addr    <= read_addr;
                r_lat_cnt <= CNT_W'(RD_LAT - 1);
            end else if (w_accept_wr) begin
                r_addr    <= write_addr;
                r_wdata   <= write_data;
                r_lat_cnt <= CNT_W'(WR_LAT - 1);
            end else if ((r_state == S_RD_WAIT || r_state == S_WR_WAIT) &&
                         r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end

            if (w_rd_fetch) begin
                r_read_data <= w_in_range ? r_mem[w_index] : BAD_WORD;
                if (!w_in_range) begin
                    r_err <= 1'b1;
                end
            end

            if (r_state == S_RD_VALID) begin
                r_rd_count <= r_rd_count + 32'd1;
            end

            if (w_wr_commit) begin
                r_wr_count <= r_wr_count + 32'd1;
                if (!w_in_range) begin
                    r_err <= 1'b1;
                end
            end

            if ((w_accept_rd || w_accept_wr) && !r_finished) begin
                r_started <= 1'b1;
            end
            if (w_counting) begin
                r_busy_cycles <= r_busy_cycles + 64'd1;
            end
            if (done) begin
                r_finished <= 1'b1;
            end
        end
    end

    // Memory is never cleared; the handshake write is issued last so it wins
    // over a same-cycle preload to the same word.
    always_ff @(posedge clk) begin
        if (pre_we) begin
            r_mem[pre_addr] <= pre_data;
        end
        if (w_wr_commit && w_in_range && !reset) begin
            r_mem[w_index] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= r_mem[pre_addr];
        end
    end

    assign read_ready  = {63'd0, (r_state == S_RD_VALID)};
    assign write_ready = {63'd0, (r_state == S_WR_VALID)};
    assign read_data   = r_read_data;
    assign dbg_data    = r_dbg_data;
    assign rd_count    = r_rd_count;
    assign wr_count    = r_wr_count;
    assign busy_cycles = r_busy_cycles;
    assign err         = r_err;
    assign finished    = r_finished;

endmodule

// File: tb/tb_host_mem_responder.sv
// Self-checking bench for host_mem_responder: wrapper-style read/write bursts
// scored against a plain array model of the host memory and counters.
module tb_host_mem_responder;

    localparam int          ADDR_WID = 16;
    localparam logic [63:0] BASE     = 64'h0;
    localparam int          RD_LAT   = 3;
    localparam int          WR_LAT   = 2;
    localparam int          DEPTH    = 1 << ADDR_WID;

    logic                clk;
    logic                reset;
    logic                read_enable;
    logic [63:0]         read_addr;
    logic                finish_read;
    logic [63:0]         read_ready;
    logic [31:0]         read_data;
    logic                write_enable;
    logic [63:0]         write_addr;
    logic [31:0]         write_data;
    logic                finish_write;
    logic [63:0]         write_ready;
    logic                done;
    logic                pre_we;
    logic [ADDR_WID-1:0] pre_addr;
    logic [31:0]         pre_data;
    logic [31:0]         dbg_data;
    logic [31:0]         rd_count;
    logic [31:0]         wr_count;
    logic [63:0]         busy_cycles;
    logic                err;
    logic                finished;

    host_mem_responder #(
        .ADDR_WID(ADDR_WID), .BASE(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .read_enable(read_enable), .read_addr(read_addr), .finish_read(finish_read),
        .read_ready(read_ready), .read_data(read_data),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .finish_write(finish_write), .write_ready(write_ready),
        .done(done), .pre_we(pre_we), .pre_addr(pre_addr), .pre_data(pre_data),
        .dbg_data(dbg_data), .rd_count(rd_count), .wr_count(wr_count),
        .busy_cycles(busy_cycles), .err(err), .finished(finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [31:0] mdl [0:DEPTH-1];
    int unsigned m_rd, m_wr;
    bit          m_err, m_fin, m_started;
    int          m_first, m_done;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_rng(input logic [63:0] a);
        logic [63:0] off;
        if (a < BASE) return 1'b0;
        off = a - BASE;
        if (off % 4 != 0) return 1'b0;
        return (off / 4) < 64'(DEPTH);
    endfunction

    function automatic int unsigned idx_of(input logic [63:0] a);
        logic [63:0] off;
        off = (a - BASE) / 4;
        return off[31:0];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        read_enable = 1'b0; write_enable = 1'b0;
        finish_read = 1'b0; finish_write = 1'b0;
        done = 1'b0; pre_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_rd = 0; m_wr = 0; m_err = 0; m_fin = 0; m_started = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rdy"}, read_ready, 64'd0);
        chk({tag, "_wrdy"}, write_ready, 64'd0);
        chk({tag, "_rdata"}, 64'(read_data), 64'd0);
        chk({tag, "_dbg"}, 64'(dbg_data), 64'd0);
        chk({tag, "_rdcnt"}, 64'(rd_count), 64'd0);
        chk({tag, "_wrcnt"}, 64'(wr_count), 64'd0);
        chk({tag, "_busy"}, busy_cycles, 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_fin"}, 64'(finished), 64'd0);
    endtask

    task automatic preload(input int unsigned idx, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = idx[ADDR_WID-1:0]; pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
        mdl[idx] = d;
    endtask

    task automatic peek(input int unsigned idx);
        pre_addr = idx[ADDR_WID-1:0];
        @(posedge clk);
        #1 chk("dbg", 64'(dbg_data), 64'(mdl[idx]));
    endtask

    // One wrapper transfer, entered in an IDLE cycle and returning in the next IDLE cycle.
    task automatic xfer(input bit wr, input logic [63:0] addr, input logic [31:0] wd,
                        input bit last, input bit early, input bit collide, input bit both);
        int          k;
        bit          got;
        bit          ok;
        logic [31:0] exp;
        int unsigned ix;
        ok = in_rng(addr);
        ix = ok ? idx_of(addr) : 0;
        if (!m_started && !m_fin) begin
            m_started = 1'b1;
            m_first   = cyc;
        end
        if (wr) begin
            write_addr = addr; write_data = wd; write_enable = 1'b1;
            if (!both) read_enable = 1'b0;
        end else begin
            read_addr = addr; read_enable = 1'b1;
            if (!both) write_enable = 1'b0;
        end
        k = 0; got = 1'b0;
        while (!got && k < 20) begin
            @(posedge clk);
            #1 k++;
            if (early && k == 1) begin
                if (wr) write_enable = 1'b0; else read_enable = 1'b0;
            end
            got = ((wr ? write_ready : read_ready) == 64'd1);
        end
        chk(wr ? "wr_lat" : "rd_lat", 64'(k), 64'(wr ? WR_LAT + 1 : RD_LAT + 1));
        if (!wr) begin
            exp = ok ? mdl[ix] : 32'hDEADBEEF;
            if (!ok) m_err = 1'b1;
            chk("rd_data", 64'(read_data), 64'(exp));
            m_rd++;
        end else begin
            if (ok) mdl[ix] = wd; else m_err = 1'b1;
            m_wr++;
            if (collide && ok) begin
                pre_we = 1'b1; pre_addr = ix[ADDR_WID-1:0]; pre_data = ~wd;
            end
        end
        $display("xfer %s addr=%0h data=%0h lat=%0d", wr ? "WR" : "RD", addr,
                 wr ? wd : read_data, k);
        @(posedge clk);
        #1 pre_we = 1'b0;
        chk("pulse", wr ? write_ready : read_ready, 64'd0);
        if (last || early) begin
            if (wr) write_enable = 1'b0; else read_enable = 1'b0;
        end else begin
            if (wr) finish_write = 1'b1; else finish_read = 1'b1;
        end
        @(posedge clk);
        #1 finish_read = 1'b0; finish_write = 1'b0;
        chk("err", 64'(err), 64'(m_err));
    endtask

    task automatic pulse_done();
        done = 1'b1;
        if (!m_fin) begin
            m_fin  = 1'b1;
            m_done = cyc;
        end
        @(posedge clk);
        #1 done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] busy_exp;
        int unsigned base_ix;
        bit          w, e, l, c;
        read_addr = '0; write_addr = '0; write_data = '0;
        pre_addr = '0; pre_data = '0;
        do_reset();
        check_zero("rst");

        // Basic read burst
        for (int i = 0; i < 4; i++) preload(i, 32'(10 * (i + 1)));
        for (int i = 0; i < 4; i++) xfer(1'b0, BASE + 64'(4 * i), 32'd0, i == 3, 1'b0, 1'b0, 1'b0);
        chk("rd_count4", 64'(rd_count), 64'(m_rd));

        // Basic write burst
        for (int i = 0; i < 4; i++) xfer(1'b1, BASE + 64'(4 * i), 32'(100 + i), i == 3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) peek(i);
        chk("wr_count4", 64'(wr_count), 64'(m_wr));

        // Misaligned read, then err stays sticky through valid traffic
        xfer(1'b0, BASE + 64'd2, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, BASE, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Both enables in IDLE: read first, then the pending write
        preload(4, 32'h1234);
        write_addr = BASE + 64'd20; write_data = 32'h5A5A; write_enable = 1'b1;
        xfer(1'b0, BASE + 64'd16, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        xfer(1'b1, BASE + 64'd20, 32'h5A5A, 1'b1, 1'b0, 1'b0, 1'b0);
        peek(5);

        // Enable dropped while waiting: transfer still completes
        xfer(1'b0, BASE + 64'd8, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        xfer(1'b1, BASE + 64'd24, 32'hCAFE, 1'b1, 1'b1, 1'b0, 1'b0);
        peek(6);

        // Reset during RD_WAIT
        read_addr = BASE; read_enable = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1; read_enable = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        m_rd = 0; m_wr = 0; m_err = 0; m_fin = 0; m_started = 0;
        check_zero("midrst");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk("midrst_norel", read_ready, 64'd0);
        end
        xfer(1'b0, BASE + 64'd4, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized traffic over a preloaded window
        base_ix = $urandom_range(0, DEPTH - 33);
        for (int i = 0; i < 32; i++) preload(base_ix + i, $urandom);
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 2) == 0);
            a = BASE + 64'(4 * (base_ix + $urandom_range(0, 31)));
            if ($urandom_range(0, 9) == 0) a = a + 64'($urandom_range(1, 3));
            else if ($urandom_range(0, 9) == 0) a = BASE + 64'(4 * DEPTH) + 64'(4 * n);
            c = w && in_rng(a) && ($urandom_range(0, 3) == 0);
            xfer(w, a, $urandom, l, e, c, 1'b0);
        end
        read_enable = 1'b0; write_enable = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) peek(base_ix + i);
        chk("rnd_rdcnt", 64'(rd_count), 64'(m_rd));
        chk("rnd_wrcnt", 64'(wr_count), 64'(m_wr));

        // Full wrapper run: read 64, kernel, write 64, done
        do_reset();
        check_zero("rst2");
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        for (int i = 0; i < 64; i++) xfer(1'b0, BASE + 64'(4 * i), 32'd0, i == 63, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++)
            xfer(1'b1, BASE + 64'(4 * (64 + i)), mdl[i] * 32'd3 + 32'd1, i == 63, 1'b0, 1'b0, 1'b0);
        pulse_done();
        busy_exp = 64'(m_done - m_first);
        chk("fin", 64'(finished), 64'd1);
        chk("busy", busy_cycles, busy_exp);
        chk("full_rdcnt", 64'(rd_count), 64'd64);
        chk("full_wrcnt", 64'(wr_count), 64'd64);
        for (int i = 0; i < 4; i++) peek(64 + $urandom_range(0, 63));
        xfer(1'b0, BASE + 64'd12, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_frozen", busy_cycles, busy_exp);
        chk("fin_sticky", 64'(finished), 64'd1);
        chk("post_rdcnt", 64'(rd_count), 64'd65);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
